// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
// Holds the shadow-stage record and the forwarding-select helper.
package hazard_pkg;

  localparam int HZ_RA_W = 3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_IMM = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [1:0] WB_LOAD = 2'b10;

  // Only the fields hazard logic needs; the datapath carries the real data.
  typedef struct packed {
    logic [HZ_RA_W-1:0] src_a;
    logic [HZ_RA_W-1:0] src_b;
    logic               u_a;
    logic               u_b;
    logic               imm;
    logic               store;
    logic [HZ_RA_W-1:0] dst;
    logic               wr;
    logic               load;
  } shadow_t;

  localparam int SHADOW_W = $bits(shadow_t);

  // A load still in EX_MEM has no data yet, so only WB can supply it.
  function automatic logic [1:0] fwd_sel(input shadow_t ex_mem,
                                         input shadow_t mem_wb,
                                         input logic [HZ_RA_W-1:0] src,
                                         input logic used);
    logic [1:0] sel;
    sel = FWD_REG;
    if (used && ex_mem.wr && !ex_mem.load && (ex_mem.dst == src)) begin
      sel = FWD_MEM;
    end else if (used && mem_wb.wr && (mem_wb.dst == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: captures the upstream record each cycle,
// or an all-zero bubble when asked.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                bubble,
  input  logic [SHADOW_W-1:0] stage_in,
  output logic [SHADOW_W-1:0] stage_out
);

  logic [SHADOW_W-1:0] stage_d;
  logic [SHADOW_W-1:0] stage_q;

  always_comb begin
    stage_d = bubble ? '0 : stage_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its neighbour held before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_out = stage_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the 4-stage 8-bit datapath:
// shadows ID_EX/EX_MEM/MEM_WB, drives forward selects, stall, flush, counters.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int RA_W   = 3,
  parameter int INST_W = 19,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] IF_ID_instruction,
  input  logic              reg_write,
  input  logic [1:0]        reg_write_mux,
  input  logic              mem_write,
  input  logic              alu_B_mux,
  input  logic              reg_B_mux,
  input  logic              uses_A,
  input  logic              uses_B,
  input  logic [1:0]        pc_mux,
  output logic [1:0]        forward_A,
  output logic [1:0]        forward_B,
  output logic              forward_mem_MEM,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        pc_mux_eff,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic [RA_W-1:0] id_src_a;
  logic [RA_W-1:0] id_src_b;
  logic [RA_W-1:0] id_dst;
  logic            id_load;
  logic            store_data_only;
  logic            hit_a;
  logic            hit_b;

  shadow_t id_rec;
  shadow_t id_ex;
  shadow_t ex_mem;
  shadow_t mem_wb;

  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] flush_count_d;
  logic [CNT_W-1:0] flush_count_q;

  logic unused_bits;

  // ---------------------------------------------------------------- decode
  always_comb begin
    id_src_a = IF_ID_instruction[10:8];
    id_src_b = reg_B_mux ? IF_ID_instruction[13:11] : IF_ID_instruction[7:5];
    id_dst   = IF_ID_instruction[13:11];
    id_load  = reg_write && (reg_write_mux == WB_LOAD);

    id_rec       = '0;
    id_rec.src_a = id_src_a;
    id_rec.src_b = id_src_b;
    id_rec.u_a   = uses_A;
    id_rec.u_b   = uses_B;
    id_rec.imm   = alu_B_mux;
    id_rec.store = mem_write;
    id_rec.dst   = id_dst;
    id_rec.wr    = reg_write;
    id_rec.load  = id_load;
  end

  // ------------------------------------------------------- shadow pipeline
  hazard_stage_reg u_id_ex (
    .clk       (clk),
    .reset     (reset),
    .bubble    (stall),
    .stage_in  (id_rec),
    .stage_out (id_ex)
  );

  hazard_stage_reg u_ex_mem (
    .clk       (clk),
    .reset     (reset),
    .bubble    (1'b0),
    .stage_in  (id_ex),
    .stage_out (ex_mem)
  );

  hazard_stage_reg u_mem_wb (
    .clk       (clk),
    .reset     (reset),
    .bubble    (1'b0),
    .stage_in  (ex_mem),
    .stage_out (mem_wb)
  );

  // ------------------------------------------------------------ forwarding
  always_comb begin
    forward_A = fwd_sel(ex_mem, mem_wb, id_ex.src_a, id_ex.u_a);
    forward_B = id_ex.imm ? FWD_IMM
                          : fwd_sel(ex_mem, mem_wb, id_ex.src_b, id_ex.u_b);
    forward_mem_MEM = ex_mem.store && mem_wb.load && (mem_wb.dst == ex_mem.src_b);
  end

  // --------------------------------------------------------------- hazards
  // A store whose B register is only its data can take a just-loaded value
  // through the MEM-stage store-data forward instead of stalling.
  always_comb begin
    store_data_only = mem_write && alu_B_mux;
    hit_a = uses_A && (id_ex.dst == id_src_a);
    hit_b = uses_B && (id_ex.dst == id_src_b) && !store_data_only;
    stall = id_ex.load && (hit_a || hit_b);
    flush = (pc_mux != 2'b00) && !stall;
    pc_mux_eff = stall ? 2'b00 : pc_mux;
  end

  // -------------------------------------------------------------- counters
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (flush && (flush_count_q != {CNT_W{1'b1}})) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  // Fields the hazard logic never inspects in the later stages.
  assign unused_bits = ^{IF_ID_instruction[INST_W-1:14], IF_ID_instruction[4:0],
                         ex_mem, mem_wb};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit: forwarding, load-use
// stall, store-data forward, flush, priority against stall, and async reset.
module tb_hazard_forward_unit;

  logic        clk;
  logic        reset;
  logic [18:0] IF_ID_instruction;
  logic        reg_write;
  logic [1:0]  reg_write_mux;
  logic        mem_write;
  logic        alu_B_mux;
  logic        reg_B_mux;
  logic        uses_A;
  logic        uses_B;
  logic [1:0]  pc_mux;
  logic [1:0]  forward_A;
  logic [1:0]  forward_B;
  logic        forward_mem_MEM;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_mux_eff;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  int vectors     = 0;
  int miscompares = 0;

  hazard_forward_unit dut (
    .clk               (clk),
    .reset             (reset),
    .IF_ID_instruction (IF_ID_instruction),
    .reg_write         (reg_write),
    .reg_write_mux     (reg_write_mux),
    .mem_write         (mem_write),
    .alu_B_mux         (alu_B_mux),
    .reg_B_mux         (reg_B_mux),
    .uses_A            (uses_A),
    .uses_B            (uses_B),
    .pc_mux            (pc_mux),
    .forward_A         (forward_A),
    .forward_B         (forward_B),
    .forward_mem_MEM   (forward_mem_MEM),
    .stall             (stall),
    .flush             (flush),
    .pc_mux_eff        (pc_mux_eff),
    .stall_count       (stall_count),
    .flush_count       (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic [2:0] d, input logic [2:0] a,
                                     input logic [2:0] b);
    logic [18:0] w;
    w        = '0;
    w[13:11] = d;
    w[10:8]  = a;
    w[7:5]   = b;
    return w;
  endfunction

  task automatic drive(input logic [18:0] ins, input logic rw, input logic [1:0] rwm,
                       input logic mw, input logic ab, input logic rbm,
                       input logic ua, input logic ub, input logic [1:0] pcm);
    IF_ID_instruction = ins;
    reg_write         = rw;
    reg_write_mux     = rwm;
    mem_write         = mw;
    alu_B_mux         = ab;
    reg_B_mux         = rbm;
    uses_A            = ua;
    uses_B            = ub;
    pc_mux            = pcm;
    #1;
  endtask

  task automatic nop();
    drive('0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic alu(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    drive(mk(d, a, b), 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
  endtask

  task automatic ld(input logic [2:0] d, input logic [2:0] a);
    drive(mk(d, a, 3'd0), 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    nop();
    check("rst_fwd_a", 16'(forward_A), 16'h0);
    check("rst_fwd_b", 16'(forward_B), 16'h0);
    check("rst_fwd_mem", 16'(forward_mem_MEM), 16'h0);
    check("rst_stall", 16'(stall), 16'h0);
    check("rst_flush", 16'(flush), 16'h0);
    check("rst_pc_eff", 16'(pc_mux_eff), 16'h0);
    check("rst_stall_cnt", stall_count, 16'h0);
    check("rst_flush_cnt", flush_count, 16'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // EX_MEM -> EX forwarding on source A
    alu(3'd1, 3'd2, 3'd3);
    tick();
    alu(3'd4, 3'd1, 3'd5);
    tick();
    nop();
    check("exmem_fwd_a", 16'(forward_A), 16'(2'b10));
    check("exmem_fwd_b", 16'(forward_B), 16'(2'b00));
    check("exmem_stall", 16'(stall), 16'h0);
    drain();

    // WB -> EX forwarding on source B
    alu(3'd1, 3'd2, 3'd3);
    tick();
    nop();
    tick();
    alu(3'd6, 3'd7, 3'd1);
    tick();
    nop();
    check("wb_fwd_b", 16'(forward_B), 16'(2'b11));
    check("wb_fwd_a", 16'(forward_A), 16'(2'b00));
    drain();

    // EX_MEM wins over MEM_WB when both write the source
    alu(3'd1, 3'd2, 3'd3);
    tick();
    alu(3'd1, 3'd5, 3'd6);
    tick();
    alu(3'd4, 3'd1, 3'd7);
    tick();
    nop();
    check("prio_fwd_a", 16'(forward_A), 16'(2'b10));
    drain();

    // load-use: one stall cycle, then WB forwarding
    ld(3'd2, 3'd0);
    tick();
    alu(3'd3, 3'd2, 3'd4);
    check("lu_stall", 16'(stall), 16'h1);
    check("lu_pc_eff", 16'(pc_mux_eff), 16'h0);
    check("lu_cnt_pre", stall_count, 16'h0);
    tick();
    check("lu_stall_gone", 16'(stall), 16'h0);
    check("lu_cnt", stall_count, 16'h1);
    tick();
    nop();
    check("lu_fwd_a", 16'(forward_A), 16'(2'b11));
    check("lu_stall_after", 16'(stall), 16'h0);
    drain();

    // ld -> st of the loaded register: no stall, store-data forward in MEM
    ld(3'd2, 3'd0);
    tick();
    drive(mk(3'd2, 3'd3, 3'd0), 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    check("ldst_stall", 16'(stall), 16'h0);
    tick();
    nop();
    check("ldst_fwd_b_imm", 16'(forward_B), 16'(2'b01));
    check("ldst_fwd_mem_early", 16'(forward_mem_MEM), 16'h0);
    tick();
    check("ldst_fwd_mem", 16'(forward_mem_MEM), 16'h1);
    drain();

    // jump redirect
    drive('0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    check("jmp_flush", 16'(flush), 16'h1);
    check("jmp_pc_eff", 16'(pc_mux_eff), 16'(2'b10));
    tick();
    nop();
    check("jmp_flush_clr", 16'(flush), 16'h0);
    check("jmp_flush_cnt", flush_count, 16'h1);
    drain();

    // redirect colliding with a load-use stall: stall wins, flush next cycle
    ld(3'd2, 3'd0);
    tick();
    drive(mk(3'd3, 3'd2, 3'd4), 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    check("coll_stall", 16'(stall), 16'h1);
    check("coll_flush", 16'(flush), 16'h0);
    check("coll_pc_eff", 16'(pc_mux_eff), 16'h0);
    tick();
    check("coll_flush_next", 16'(flush), 16'h1);
    check("coll_pc_eff_next", 16'(pc_mux_eff), 16'(2'b01));
    tick();
    nop();
    check("coll_stall_cnt", stall_count, 16'h2);
    check("coll_flush_cnt", flush_count, 16'h2);
    drain();

    // immediate overrides a matching EX_MEM destination on B
    alu(3'd5, 3'd1, 3'd2);
    tick();
    drive(mk(3'd6, 3'd1, 3'd5), 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    nop();
    check("imm_fwd_b", 16'(forward_B), 16'(2'b01));
    check("imm_fwd_a", 16'(forward_A), 16'(2'b00));
    drain();

    // asynchronous reset in the middle of a stall
    ld(3'd2, 3'd0);
    tick();
    alu(3'd3, 3'd2, 3'd4);
    check("mid_stall_pre", 16'(stall), 16'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_stall", 16'(stall), 16'h0);
    check("mid_rst_stall_cnt", stall_count, 16'h0);
    check("mid_rst_flush_cnt", flush_count, 16'h0);
    tick();
    reset = 1'b0;
    nop();
    tick();
    check("post_rst_stall_cnt", stall_count, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
